// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing with JAL/branch-prediction/JALR stall
// handling and a circular fetch queue feeding the decoder.
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  output logic [31:0]                  fetch_addr,
  input  logic                         inst_available,
  input  logic [31:0]                  inst,
  input  logic                         bp_taken,
  input  logic [31:0]                  bp_target,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_addr,
  input  logic                         jalr_done,
  input  logic [31:0]                  jalr_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic                         out_pred_taken,
  output logic [$clog2(QUEUE_DEPTH):0] out_count
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic {FETCH, STALL_JALR} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc, w_pc_nxt;
  logic [AW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_q_inst [QUEUE_DEPTH];
  logic [31:0]     r_q_pc   [QUEUE_DEPTH];
  logic            r_q_pt   [QUEUE_DEPTH];

  logic            w_push, w_pop, w_is_jal, w_is_jalr, w_pred;
  logic [31:0]     w_jimm;

  assign w_is_jal  = (inst[6:0] == OP_JAL);
  assign w_is_jalr = (inst[6:0] == OP_JALR);
  assign w_jimm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign w_push    = (r_state == FETCH) && inst_available && (r_count != FULL);
  assign w_pop     = out_valid && out_ready;

  assign fetch_addr     = r_pc;
  assign out_valid      = (r_count != '0);
  assign out_count      = r_count;
  assign out_inst       = out_valid ? r_q_inst[r_head] : 32'h0;
  assign out_pc         = out_valid ? r_q_pc[r_head]   : 32'h0;
  assign out_pred_taken = out_valid ? r_q_pt[r_head]   : 1'b0;

  // Next-PC / next-state for the normal (no flush) path.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pred      = 1'b0;
    if (r_state == STALL_JALR) begin
      if (jalr_done) begin
        w_state_nxt = FETCH;
        w_pc_nxt    = jalr_addr;
      end
    end else if (w_push) begin
      if (w_is_jal) begin
        w_pc_nxt = r_pc + w_jimm;
        w_pred   = 1'b1;
      end else if (w_is_jalr) begin
        w_state_nxt = STALL_JALR;
      end else if (bp_taken) begin
        w_pc_nxt = bp_target;
        w_pred   = 1'b1;
      end else begin
        w_pc_nxt = r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (redirect_valid) begin
        r_state <= FETCH;
        r_pc    <= redirect_addr;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_pc    <= w_pc_nxt;
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !redirect_valid && w_push) begin
      r_q_inst[r_tail] <= inst;
      r_q_pc[r_tail]   <= r_pc;
      r_q_pt[r_tail]   <= w_pred;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill/full, JAL, bp, JALR stall, redirect, freeze, reset.
module tb_fetch_unit;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] fetch_addr;
  logic        inst_available;
  logic [31:0] inst;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        jalr_done;
  logic [31:0] jalr_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        out_pred_taken;
  logic [3:0]  out_count;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] JAL_M8 = 32'hFF9FF06F; // jal x0, -8
  localparam logic [31:0] JALR   = 32'h000080E7;

  fetch_unit #(.QUEUE_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .fetch_addr(fetch_addr),
    .inst_available(inst_available), .inst(inst), .bp_taken(bp_taken), .bp_target(bp_target),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .jalr_done(jalr_done), .jalr_addr(jalr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_count(out_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1; redirect_addr = a;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; inst_available = 1'b0; inst = ADDI;
    bp_taken = 1'b0; bp_target = '0; redirect_valid = 1'b0; redirect_addr = '0;
    jalr_done = 1'b0; jalr_addr = '0; out_ready = 1'b0;

    step(2);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fa",    fetch_addr, 32'h0);
    chk("rst_inst",  out_inst, 32'h0);

    // sequential fill
    rst_in = 1'b1; inst_available = 1'b1;
    step(1);
    chk("fill1_count", 32'(out_count), 32'd1);
    chk("fill1_fa",    fetch_addr, 32'd4);
    chk("fill1_pc",    out_pc, 32'd0);
    chk("fill1_inst",  out_inst, ADDI);
    chk("fill1_pt",    32'(out_pred_taken), 32'd0);
    step(7);
    chk("fill8_count", 32'(out_count), 32'd8);
    chk("fill8_fa",    fetch_addr, 32'd32);
    step(2);
    chk("full_count",  32'(out_count), 32'd8);
    chk("full_fa",     fetch_addr, 32'd32);

    // full + pop: pop only, then steady push+pop across pointer wrap
    out_ready = 1'b1;
    step(1);
    chk("popfull_count", 32'(out_count), 32'd7);
    chk("popfull_fa",    fetch_addr, 32'd32);
    chk("popfull_pc",    out_pc, 32'd4);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("steady_count", 32'(out_count), 32'd7);
      chk("steady_pc",    out_pc, 32'(4 + 4*k));
    end
    chk("steady_fa", fetch_addr, 32'd112);

    // reset mid-stream wins over rdy_in=0
    rst_in = 1'b0; rdy_in = 1'b0;
    step(1);
    chk("mrst_count", 32'(out_count), 32'd0);
    chk("mrst_fa",    fetch_addr, 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc",    out_pc, 32'h0);

    // rdy_in freeze
    rst_in = 1'b1; rdy_in = 1'b1; out_ready = 1'b0;
    step(2);
    chk("prefrz_count", 32'(out_count), 32'd2);
    rdy_in = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h999;
    step(3);
    redirect_valid = 1'b0;
    chk("frz_count", 32'(out_count), 32'd2);
    chk("frz_fa",    fetch_addr, 32'd8);
    chk("frz_pc",    out_pc, 32'd0);
    rdy_in = 1'b1; out_ready = 1'b0;

    // JAL at 0x100, imm -8
    redirect_to(32'h100);
    chk("redir_count", 32'(out_count), 32'd0);
    chk("redir_fa",    fetch_addr, 32'h100);
    inst = JAL_M8;
    step(1);
    chk("jal_fa",    fetch_addr, 32'h0F8);
    chk("jal_pt",    32'(out_pred_taken), 32'd1);
    chk("jal_pc",    out_pc, 32'h100);
    chk("jal_inst",  out_inst, JAL_M8);
    inst_available = 1'b0;
    redirect_to(32'h4);
    inst_available = 1'b1;
    step(1);
    chk("jalwrap_fa", fetch_addr, 32'hFFFF_FFFC);

    // predictor taken
    inst_available = 1'b0; inst = ADDI;
    redirect_to(32'h20);
    inst_available = 1'b1; bp_taken = 1'b1; bp_target = 32'h300;
    step(1);
    bp_taken = 1'b0;
    chk("bp_fa", fetch_addr, 32'h300);
    chk("bp_pt", 32'(out_pred_taken), 32'd1);
    chk("bp_pc", out_pc, 32'h20);

    // JALR stall
    inst_available = 1'b0;
    redirect_to(32'h40);
    inst_available = 1'b1; inst = JALR;
    step(1);
    chk("jalr_count", 32'(out_count), 32'd1);
    chk("jalr_pt",    32'(out_pred_taken), 32'd0);
    inst = ADDI;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("stall_fa",    fetch_addr, 32'h40);
      chk("stall_count", 32'(out_count), 32'd1);
    end
    jalr_done = 1'b1; jalr_addr = 32'h200;
    step(1);
    jalr_done = 1'b0;
    chk("jdone_fa",    fetch_addr, 32'h200);
    chk("jdone_count", 32'(out_count), 32'd1);
    step(1);
    chk("resume_fa",    fetch_addr, 32'h204);
    chk("resume_count", 32'(out_count), 32'd2);

    // redirect with 5 queued entries and concurrent pop
    inst_available = 1'b0;
    redirect_to(32'h0);
    inst_available = 1'b1;
    step(5);
    chk("five_count", 32'(out_count), 32'd5);
    out_ready = 1'b1;
    redirect_to(32'h80);
    chk("rflush_count", 32'(out_count), 32'd0);
    chk("rflush_fa",    fetch_addr, 32'h80);
    chk("rflush_valid", 32'(out_valid), 32'd0);
    chk("rflush_inst",  out_inst, 32'h0);
    out_ready = 1'b0;

    // redirect beats jalr_done in STALL_JALR
    inst = JALR;
    step(1);
    chk("stall2_fa", fetch_addr, 32'h80);
    inst = ADDI; jalr_done = 1'b1; jalr_addr = 32'h600;
    redirect_to(32'h500);
    jalr_done = 1'b0;
    chk("rvj_fa",    fetch_addr, 32'h500);
    chk("rvj_count", 32'(out_count), 32'd0);
    step(1);
    chk("rvj_fetch_fa", fetch_addr, 32'h504);

    // jalr_done ignored in FETCH
    jalr_done = 1'b1; jalr_addr = 32'h900;
    step(1);
    jalr_done = 1'b0;
    chk("jdfetch_fa", fetch_addr, 32'h508);

    // pop on empty ignored
    inst_available = 1'b0;
    redirect_to(32'h0);
    out_ready = 1'b1;
    step(1);
    chk("popempty_count", 32'(out_count), 32'd0);
    chk("popempty_fa",    fetch_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 8, fetch-queue entries; power of two, 2..64.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, PC loaded on reset.
REQ-003 SHALL have ports in this order: clk_in  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_in  input  1  synchronous reset, active-low.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 fetch_addr  output  32  current PC to icache.
REQ-007 inst_available  input  1  icache hit for fetch_addr this cycle.
REQ-008 inst  input  32  instruction word at fetch_addr.
REQ-009 bp_taken  input  1  predictor says branch at fetch_addr is taken.
REQ-010 bp_target  input  32  predicted target.
REQ-011 redirect_valid  input  1  mispredict flush request.
REQ-012 redirect_addr  input  32  correct PC after mispredict.
REQ-013 jalr_done  input  1  JALR target resolved.
REQ-014 jalr_addr  input  32  resolved JALR target.
REQ-015 out_valid  output  1  queue head valid.
REQ-016 out_ready  input  1  decoder pops head.
REQ-017 out_inst  output  32  head instruction.
REQ-018 out_pc  output  32  head PC.
REQ-019 out_pred_taken  output  1  head predicted taken (bp or JAL).
REQ-020 out_count  output  $clog2(QUEUE_DEPTH)+1  queued entries.

Function
REQ-021 SHALL hold a two-state FSM: FETCH, STALL_JALR.
REQ-022 fetch_addr SHALL equal the PC register combinationally.
REQ-023 In FETCH, push SHALL occur when inst_available=1 and out_count<QUEUE_DEPTH (registered count; no push when full even if pop same cycle).
REQ-024 On push, entry {inst, PC, pred_taken} SHALL be written at tail; visible at head no earlier than next cycle.
REQ-025 Next PC on push: JAL (opcode 1101111) -> PC + sign-extended J-immediate, pred_taken=1; else bp_taken -> bp_target, pred_taken=1; else PC+4, pred_taken=0; 32-bit wrap-around addition.
REQ-026 JALR (opcode 1100111) push SHALL keep PC, pred_taken=0, move FSM to STALL_JALR.
REQ-027 In STALL_JALR no push SHALL occur; jalr_done=1 SHALL load PC<=jalr_addr and return to FETCH next cycle.
REQ-028 No push when inst_available=0; PC holds.
REQ-029 Pop SHALL occur when out_valid=1 and out_ready=1; pop with empty queue SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave out_count unchanged and advance both pointers.
REQ-031 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-032 redirect_valid=1 SHALL, next cycle: PC<=redirect_addr, queue emptied (out_count=0, out_valid=0), FSM=FETCH; same-cycle push/pop discarded.
REQ-033 Priority per cycle: reset > !rdy_in > redirect_valid > jalr_done (only in STALL_JALR) > push/pop.
REQ-034 jalr_done in FETCH SHALL be ignored.
REQ-035 rdy_in=0 SHALL freeze PC, FSM, queue, count; pops and pushes ignored; outputs reflect frozen state.

Reset
REQ-036 rst_in=0 at clock edge SHALL set PC=RESET_PC, FSM=FETCH, pointers=0, out_count=0, out_valid=0, regardless of rdy_in or in-flight operations.
REQ-037 out_inst, out_pc, out_pred_taken SHALL be 0 while out_valid=0.

Verification
REQ-038 Sequential fill: RESET_PC=0, inst_available=1, ADDI words, out_ready=0 -> PCs 0,4,...,28 queued, out_count=8, fetch_addr holds 32, no 9th push.
REQ-039 JAL at 0x100 with imm=-8 -> entry pred_taken=1, next fetch_addr=0x0F8; imm wrapping at PC=0x4 with imm=-8 -> 0xFFFFFFFC.
REQ-040 JALR at 0x40 -> pushed, FSM STALL_JALR, fetch_addr stays 0x40 for 5 cycles; jalr_done with 0x200 -> fetch_addr=0x200 next cycle, pushes resume.
REQ-041 Queue with 5 entries, redirect_valid with 0x80 plus out_ready=1 same cycle -> next cycle out_count=0, fetch_addr=0x80; redirect during STALL_JALR with jalr_done also high -> redirect_addr wins.
REQ-042 Full queue, out_ready=1, inst_available=1 -> pop only, out_count=7; following cycle push+pop -> count stays 7, pointer wrap checked over 20 cycles; rst_in=0 mid-stream -> count 0, fetch_addr=RESET_PC.
